// File: rtl/otp_gen_ctrl.sv
// OTP generation sequencer: steps a 16-bit Fibonacci LFSR and draws four BCD digits
// by rejection sampling, presenting the packed word with a one-cycle latch pulse.
module otp_gen_ctrl #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          REJ_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gen_req,
    input  logic        gen_abort,
    input  logic [15:0] entropy_in,
    input  logic        entropy_valid,
    output logic [15:0] lfsr_digit,
    output logic        lfsr_latch,
    output logic        busy,
    output logic [7:0]  gen_count
);

    localparam int REJ_W = (REJ_LIMIT < 1) ? 1 : $clog2(REJ_LIMIT + 1);

    // state | meaning
    // IDLE  | LFSR holds; entropy reseed and gen_req accepted
    // DRAW  | LFSR steps each cycle; candidate nibbles accepted or rejected
    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        q_q, q_d;
    logic [11:0]        buf_q, buf_d;
    logic [15:0]        digit_q, digit_d;
    logic [1:0]         k_q, k_d;
    logic [REJ_W-1:0]   rej_q, rej_d;
    logic               latch_q, latch_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [15:0]        step;
    logic [15:0]        mix;
    logic [3:0]         cand;
    logic [3:0]         dig;
    logic               accept;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        buf_d   = buf_q;
        digit_d = digit_q;
        k_d     = k_q;
        rej_d   = rej_q;
        latch_d = 1'b0;
        cnt_d   = cnt_q;
        step    = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
        mix     = q_q ^ entropy_in;
        cand    = step[3:0];
        dig     = cand;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (entropy_valid) begin
                    q_d = (mix == 16'h0000) ? SEED : mix;
                end
                if (gen_req) begin
                    state_d = DRAW;
                    k_d     = 2'd0;
                    rej_d   = '0;
                end
            end
            DRAW: begin
                // a zero state would lock the LFSR, so recover to the seed
                q_d = (step == 16'h0000) ? SEED : step;
                if (cand <= 4'd9) begin
                    accept = 1'b1;
                end else if (rej_q == REJ_W'(REJ_LIMIT)) begin
                    accept = 1'b1;
                    dig    = cand - 4'd10;
                end else begin
                    rej_d = rej_q + REJ_W'(1);
                end

                if (gen_abort) begin
                    state_d = IDLE;
                    k_d     = 2'd0;
                    rej_d   = '0;
                end else if (accept) begin
                    k_d   = k_q + 2'd1;
                    rej_d = '0;
                    case (k_q)
                        2'd0: buf_d[11:8] = dig;
                        2'd1: buf_d[7:4]  = dig;
                        2'd2: buf_d[3:0]  = dig;
                        default: begin
                            digit_d = {buf_q, dig};
                            latch_d = 1'b1;
                            cnt_d   = cnt_q + 8'd1;
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= SEED;
            buf_q   <= 12'h000;
            digit_q <= 16'h0000;
            k_q     <= 2'd0;
            rej_q   <= '0;
            latch_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            buf_q   <= buf_d;
            digit_q <= digit_d;
            k_q     <= k_d;
            rej_q   <= rej_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lfsr_digit = digit_q;
    assign lfsr_latch = latch_q;
    assign busy       = (state_q == DRAW);
    assign gen_count  = cnt_q;

endmodule

// File: tb/tb_otp_gen_ctrl.sv
// Randomized bench for otp_gen_ctrl with a transaction-level OTP model, plus
// directed checks on two small-seed instances.
module tb_otp_gen_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          REJ  = 4;

    logic        clk = 1'b0;
    logic        reset, gen_req, gen_abort, entropy_valid;
    logic [15:0] entropy_in;
    logic [15:0] lfsr_digit;
    logic        lfsr_latch, busy;
    logic [7:0]  gen_count;

    logic        rst2, req2;
    logic [15:0] digit9, digit7;
    logic        latch9, latch7, busy9, busy7;
    logic [7:0]  count9, count7;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq;
    logic [15:0] mdigit;
    logic [7:0]  mcount;

    always #5 clk = ~clk;

    otp_gen_ctrl #(.SEED(SEED), .REJ_LIMIT(REJ)) dut (
        .clk(clk), .reset(reset), .gen_req(gen_req), .gen_abort(gen_abort),
        .entropy_in(entropy_in), .entropy_valid(entropy_valid),
        .lfsr_digit(lfsr_digit), .lfsr_latch(lfsr_latch), .busy(busy), .gen_count(gen_count)
    );

    otp_gen_ctrl #(.SEED(16'h0009), .REJ_LIMIT(4)) dut9 (
        .clk(clk), .reset(rst2), .gen_req(req2), .gen_abort(1'b0),
        .entropy_in(16'h0000), .entropy_valid(1'b0),
        .lfsr_digit(digit9), .lfsr_latch(latch9), .busy(busy9), .gen_count(count9)
    );

    otp_gen_ctrl #(.SEED(16'h0007), .REJ_LIMIT(1)) dut7 (
        .clk(clk), .reset(rst2), .gen_req(req2), .gen_abort(1'b0),
        .entropy_in(16'h0000), .entropy_valid(1'b0),
        .lfsr_digit(digit7), .lfsr_latch(latch7), .busy(busy7), .gen_count(count7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic [15:0] n;
        n = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        return (n == 16'h0000) ? SEED : n;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] q, input int n);
        logic [15:0] r = q;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    function automatic logic [15:0] reseed(input logic [15:0] q, input logic [15:0] e);
        return ((q ^ e) == 16'h0000) ? SEED : (q ^ e);
    endfunction

    // Draws digits from a starting state and reports the OTP and cycles needed.
    task automatic otp_model(input logic [15:0] q0, output logic [15:0] otp, output int lat);
        logic [15:0] q = q0;
        int ndig = 0;
        int rej = 0;
        int c, d;
        otp = 16'h0000;
        lat = 0;
        while (ndig < 4) begin
            q = lfsr_next(q);
            lat++;
            c = int'(q[3:0]);
            if (c <= 9) d = c;
            else if (rej == REJ) d = c - 10;
            else begin
                rej++;
                continue;
            end
            otp = otp | 16'(d << (12 - 4 * ndig));
            ndig++;
            rej = 0;
        end
    endtask

    task automatic gen_one(input bit use_ent, input logic [15:0] ent, input int abort_at, input bit noise);
        logic [15:0] otp;
        logic [15:0] d;
        int lat;
        int ab;
        bit done = 0;
        if (use_ent) mq = reseed(mq, ent);
        otp_model(mq, otp, lat);
        ab = (abort_at > lat) ? lat : abort_at;
        gen_req = 1'b1;
        entropy_valid = use_ent;
        entropy_in = ent;
        @(negedge clk);
        gen_req = 1'b0;
        entropy_valid = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        check("latch_one_cycle", 32'(lfsr_latch), 32'd0);
        for (int i = 1; i <= 4 * (REJ + 1) + 2 && !done; i++) begin
            gen_abort = (i == ab);
            if (noise) begin
                gen_req = 1'($urandom_range(0, 1));
                entropy_valid = 1'($urandom_range(0, 1));
                entropy_in = 16'($urandom);
            end
            @(negedge clk);
            gen_abort = 1'b0;
            gen_req = 1'b0;
            entropy_valid = 1'b0;
            if (i == ab) begin
                mq = lfsr_adv(mq, i);
                check("abort_latch", 32'(lfsr_latch), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_digit", 32'(lfsr_digit), 32'(mdigit));
                check("abort_count", 32'(gen_count), 32'(mcount));
                done = 1;
            end else if (lfsr_latch) begin
                mq = lfsr_adv(mq, lat);
                mdigit = otp;
                mcount = mcount + 8'd1;
                check("latency", 32'(i), 32'(lat));
                check("otp", 32'(lfsr_digit), 32'(mdigit));
                check("count", 32'(gen_count), 32'(mcount));
                check("busy_fall", 32'(busy), 32'd0);
                d = lfsr_digit;
                for (int j = 0; j < 4; j++) check("nibble_bcd", 32'(d[4*j +: 4] <= 4'd9), 32'd1);
                done = 1;
            end
        end
        if (!done) check("latch_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            entropy_valid = 1'($urandom_range(0, 1));
            entropy_in = 16'($urandom);
            gen_abort = 1'($urandom_range(0, 1));
            if (entropy_valid) mq = reseed(mq, entropy_in);
            @(negedge clk);
            entropy_valid = 1'b0;
            gen_abort = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq = SEED;
        mdigit = 16'h0000;
        mcount = 8'd0;
    endtask

    initial begin
        logic [15:0] first_otp;
        int first_lat;
        int lat9, lat7;

        reset = 1'b1; rst2 = 1'b1; req2 = 1'b0;
        gen_req = 1'b0; gen_abort = 1'b0; entropy_valid = 1'b0; entropy_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_digit", 32'(lfsr_digit), 32'h0);
        check("rst_latch", 32'(lfsr_latch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(gen_count), 32'd0);
        reset = 1'b0; rst2 = 1'b0;
        mq = SEED; mdigit = 16'h0000; mcount = 8'd0;

        // small-seed instances with hand-derived results
        req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        lat9 = 0; lat7 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (latch9 && lat9 == 0) lat9 = i;
            if (latch7 && lat7 == 0) lat7 = i;
        end
        check("seed9_latency", 32'(lat9), 32'd4);
        check("seed9_otp", 32'(digit9), 32'h2480);
        check("seed9_count", 32'(count9), 32'd1);
        check("seed7_latency", 32'(lat7), 32'd5);
        check("seed7_otp", 32'(digit7), 32'h2800);
        check("seed7_count", 32'(count7), 32'd1);

        otp_model(SEED, first_otp, first_lat);
        gen_one(0, 16'h0000, 0, 0);
        check("first_otp", 32'(lfsr_digit), 32'(first_otp));

        // reseed that cancels to zero must fall back to the seed
        pulse_reset();
        entropy_valid = 1'b1; entropy_in = 16'hACE1;
        @(negedge clk);
        entropy_valid = 1'b0;
        mq = reseed(mq, 16'hACE1);
        gen_one(0, 16'h0000, 0, 0);
        check("reseed_zero_otp", 32'(lfsr_digit), 32'(first_otp));

        gen_one(0, 16'h0000, 2, 1);
        for (int n = 0; n < 30; n++) begin
            idle_cycles($urandom_range(0, 2));
            gen_one(1'($urandom_range(0, 1)), 16'($urandom),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0, 1);
        end

        // reset in the middle of a draw
        gen_req = 1'b1;
        @(negedge clk);
        gen_req = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset();
        check("middraw_rst_digit", 32'(lfsr_digit), 32'h0);
        check("middraw_rst_latch", 32'(lfsr_latch), 32'd0);
        check("middraw_rst_busy", 32'(busy), 32'd0);
        check("middraw_rst_count", 32'(gen_count), 32'd0);

        for (int n = 0; n < 256; n++) begin
            gen_one($urandom_range(0, 3) == 0, 16'($urandom), 0, 1'($urandom_range(0, 1)));
        end
        check("count_wrap", 32'(gen_count), 32'd0);
        @(negedge clk);
        check("final_latch_clear", 32'(lfsr_latch), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
